// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment frame capture block: segment patterns
// (bit6=a .. bit0=g), decoded codes and the capture FSM state type.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_P     = 7'b1100111;

  localparam logic [3:0] CODE_BLANK   = 4'd10;
  localparam logic [3:0] CODE_DASH    = 4'd11;
  localparam logic [3:0] CODE_A       = 4'd12;
  localparam logic [3:0] CODE_P       = 4'd13;
  localparam logic [3:0] CODE_INVALID = 4'd15;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to 4-bit code decoder; unknown patterns
// map to the invalid code, code 14 is never produced.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code
);

  always_comb begin
    code = CODE_INVALID;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      SEG_DASH:  code = CODE_DASH;
      SEG_A:     code = CODE_A;
      SEG_P:     code = CODE_P;
      default:   code = CODE_INVALID;
    endcase
  end

endmodule

// File: rtl/seg_frame_capture.sv
// Captures a multiplexed seven-segment display: each digit is written once it has
// been stable long enough, and a full frame is published when every slot is fresh.
module seg_frame_capture
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 6,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] frame,
  output logic                    frame_valid,
  output logic                    frame_bad,
  output logic                    sel_error
);

  localparam int unsigned SW         = 7 + NUM_DIGITS;
  localparam logic [7:0]  LAST_COUNT = 8'(STABLE_CYCLES - 1);

  logic [6:0]                 seg_q;
  logic [NUM_DIGITS-1:0]      sel_q;
  logic [SW-1:0]              prev_q;
  logic [7:0]                 cnt_q, cnt_d;
  state_e                     state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0] slots_q, slots_d;
  logic [NUM_DIGITS-1:0][3:0] frame_q, frame_d;
  logic [NUM_DIGITS-1:0]      seen_q, seen_d;
  logic                       bad_q, bad_d;
  logic                       fv_q, fv_d;
  logic                       changed, sel_onehot, sel_multi, wr_en, any_invalid;
  logic [3:0]                 code;

  seg_pattern_decode u_decode (
    .seg  (seg_q),
    .code (code)
  );

  assign changed    = {seg_q, sel_q} != prev_q;
  assign sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - NUM_DIGITS'(1))) == '0);
  assign sel_multi  = (sel_q != '0) && !sel_onehot;
  // Counter value for the current sample run; 0 on the first cycle of a new value.
  assign cnt_d      = changed ? 8'd0 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);

  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    sel_error = 1'b0;
    case (state_q)
      StIdle: begin
        if (sel_onehot) begin
          state_d = StSettle;
        end else begin
          sel_error = sel_multi && changed;
        end
      end
      StSettle, StHold: begin
        if (changed) begin
          if (sel_onehot) begin
            state_d = StSettle;
          end else begin
            state_d   = StIdle;
            sel_error = sel_multi;
          end
        end else if (state_q == StSettle && cnt_d == LAST_COUNT) begin
          wr_en   = 1'b1;
          state_d = StHold;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    slots_d     = slots_q;
    seen_d      = seen_q;
    frame_d     = frame_q;
    bad_d       = bad_q;
    fv_d        = 1'b0;
    any_invalid = 1'b0;
    if (wr_en) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (sel_q[i]) slots_d[i] = code;
      end
      seen_d = seen_q | sel_q;
    end
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      any_invalid = any_invalid | (slots_d[i] == CODE_INVALID);
    end
    // Publishing on the completing write edge puts frame_valid in the very next cycle.
    if (wr_en && (&seen_d)) begin
      frame_d = slots_d;
      bad_d   = any_invalid;
      fv_d    = 1'b1;
      seen_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= '0;
      sel_q   <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      state_q <= StIdle;
      slots_q <= {NUM_DIGITS{CODE_BLANK}};
      seen_q  <= '0;
      frame_q <= {NUM_DIGITS{CODE_BLANK}};
      bad_q   <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      seg_q   <= seg;
      sel_q   <= digit_sel;
      prev_q  <= {seg_q, sel_q};
      cnt_q   <= cnt_d;
      state_q <= state_d;
      slots_q <= slots_d;
      seen_q  <= seen_d;
      frame_q <= frame_d;
      bad_q   <= bad_d;
      fv_q    <= fv_d;
    end
  end

  assign frame       = frame_q;
  assign frame_bad   = bad_q;
  assign frame_valid = fv_q;

endmodule
